// File: rtl/upsample_pkg.sv
// rtl/upsample_pkg.sv - shared types and width helper for the nearest-neighbour up-sampler
package upsample_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LANES_DEF  = 1;

  typedef logic [LANES_DEF*DATA_W_DEF-1:0] pixel_t;
  typedef logic bank_sel_t;

  // Width of a counter holding 0..n-1, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upsample_bank_ram.sv
// rtl/upsample_bank_ram.sv - two-bank row store, one write port and one registered read port
module upsample_bank_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // The bank bit is the address MSB, so a non-power-of-two row leaves unused words
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/upsample_nn_line_buffer.sv
// rtl/upsample_nn_line_buffer.sv - streaming nearest-neighbour up-sampler over ping-pong row banks
module upsample_nn_line_buffer
  import upsample_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int IN_W   = 64,
  parameter int IN_H   = 64,
  parameter int SCALE  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last_col,
  output logic                    out_last_frame,
  output logic                    busy
);

  localparam int PIX_W  = LANES * DATA_W;
  localparam int COL_W  = clog2_min1(IN_W);
  localparam int ADDR_W = $clog2(IN_W) + 1;
  localparam int ROW_W  = clog2_min1(IN_H);
  localparam int REP_W  = clog2_min1(SCALE);
  localparam int OROW_W = clog2_min1(IN_H * SCALE);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_H - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(SCALE - 1);
  localparam logic [OROW_W-1:0] OROW_LAST = OROW_W'(IN_H * SCALE - 1);

  logic              ready_en;
  logic [1:0]        full;
  bank_sel_t         wr_bank;
  bank_sel_t         rd_bank;
  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  in_row;

  logic [REP_W-1:0]  hx;
  logic [COL_W-1:0]  src_col;
  logic [REP_W-1:0]  vy;
  logic [OROW_W-1:0] out_row;

  logic              s1_valid;
  logic              s1_last_col;
  logic              s1_last_frame;
  logic [PIX_W-1:0]  rd_data;

  logic accept;
  logic wr_row_done;
  logic adv;
  logic issue;
  logic hx_last;
  logic col_last;
  logic vy_last;
  logic orow_last;
  logic rd_free;

  // ready_en keeps in_ready low until the first edge after reset or flush
  assign in_ready    = ready_en & ~full[wr_bank];
  assign accept      = in_valid & in_ready;
  assign wr_row_done = accept & (wr_col == COL_LAST);

  assign adv       = ~out_valid | out_ready;
  assign issue     = adv & full[rd_bank];
  assign hx_last   = (hx == REP_LAST);
  assign col_last  = (src_col == COL_LAST);
  assign vy_last   = (vy == REP_LAST);
  assign orow_last = (out_row == OROW_LAST);
  assign rd_free   = issue & hx_last & col_last & vy_last;

  assign busy = full[0] | full[1] | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_col   <= '0;
      in_row   <= '0;
      wr_bank  <= 1'b0;
    end else if (flush) begin
      ready_en <= 1'b0;
      wr_col   <= '0;
      in_row   <= '0;
      wr_bank  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (wr_row_done) begin
          wr_col  <= '0;
          wr_bank <= ~wr_bank;
          in_row  <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  // Write and read always target opposite banks, so set and free never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else if (flush) begin
      full <= 2'b00;
    end else begin
      if (wr_row_done) full[wr_bank] <= 1'b1;
      if (rd_free)     full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx      <= '0;
      src_col <= '0;
      vy      <= '0;
      out_row <= '0;
      rd_bank <= 1'b0;
    end else if (flush) begin
      hx      <= '0;
      src_col <= '0;
      vy      <= '0;
      out_row <= '0;
      rd_bank <= 1'b0;
    end else if (issue) begin
      if (hx_last) begin
        hx <= '0;
        if (col_last) begin
          src_col <= '0;
          out_row <= orow_last ? '0 : out_row + 1'b1;
          if (vy_last) begin
            vy      <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            vy <= vy + 1'b1;
          end
        end else begin
          src_col <= src_col + 1'b1;
        end
      end else begin
        hx <= hx + 1'b1;
      end
    end
  end

  // Address stage and output register advance together, so a stall freezes the whole pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_last_col    <= 1'b0;
      s1_last_frame  <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last_col   <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (flush) begin
      s1_valid       <= 1'b0;
      s1_last_col    <= 1'b0;
      s1_last_frame  <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last_col   <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (adv) begin
      s1_valid       <= issue;
      s1_last_col    <= issue & hx_last & col_last;
      s1_last_frame  <= issue & hx_last & col_last & orow_last;
      out_valid      <= s1_valid;
      out_last_col   <= s1_last_col;
      out_last_frame <= s1_last_frame;
      if (s1_valid) out_data <= rd_data;
    end
  end

  upsample_bank_ram #(
    .WIDTH  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_bank_ram (
    .clk     (clk),
    .wr_en   (accept & ~flush),
    .wr_addr ({wr_bank, wr_col}),
    .wr_data (in_data),
    .rd_en   (issue & ~flush),
    .rd_addr ({rd_bank, src_col}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_upsample_nn_line_buffer.sv
// tb/tb_upsample_nn_line_buffer.sv - directed self-checking bench for three up-sampler configurations
module tb_upsample_nn_line_buffer;
  import upsample_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n          [3];
  logic   flush          [3];
  logic   in_valid       [3];
  logic   in_ready       [3];
  pixel_t in_data        [3];
  logic   out_valid      [3];
  logic   out_ready      [3];
  pixel_t out_data       [3];
  logic   out_last_col   [3];
  logic   out_last_frame [3];
  logic   busy           [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  upsample_nn_line_buffer #(.DATA_W(16), .LANES(1), .IN_W(4), .IN_H(2), .SCALE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last_col(out_last_col[0]), .out_last_frame(out_last_frame[0]), .busy(busy[0])
  );

  upsample_nn_line_buffer #(.DATA_W(16), .LANES(1), .IN_W(5), .IN_H(4), .SCALE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last_col(out_last_col[1]), .out_last_frame(out_last_frame[1]), .busy(busy[1])
  );

  upsample_nn_line_buffer #(.DATA_W(16), .LANES(1), .IN_W(8), .IN_H(3), .SCALE(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last_col(out_last_col[2]), .out_last_frame(out_last_frame[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Input pixel i: col + 16*row, later frames offset by 256 so frame wrap is visible
  function automatic logic [15:0] in_pix(input int i, input int w, input int h);
    int fr, fi;
    fr = i / (w * h);
    fi = i % (w * h);
    return 16'((fi % w) + 16 * (fi / w) + 256 * fr);
  endfunction

  function automatic logic [15:0] out_pix(input int k, input int w, input int h, input int s);
    int fr, fk, orow, ocol;
    fr   = k / (w * s * h * s);
    fk   = k % (w * s * h * s);
    orow = fk / (w * s);
    ocol = fk % (w * s);
    return 16'((ocol / s) + 16 * (orow / s) + 256 * fr);
  endfunction

  // ready_mode: 0 always ready, 1 random 50%, 2 never ready; abort_at > 0 stops after that many accepts
  task automatic run_stream(input int id, input int w, input int h, input int s, input int frames,
                            input int ready_mode, input int abort_at,
                            output int first_valid, output int row0_done, output int tx_row3,
                            output int ready_full);
    int in_idx, out_idx, n_in, n_out, fk;
    bit seen_full;
    in_idx = 0; out_idx = 0; seen_full = 0;
    first_valid = -1; row0_done = -1; tx_row3 = -1; ready_full = -1;
    n_in  = w * h * frames;
    n_out = n_in * s * s;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (in_idx >= n_in && out_idx >= n_out) break;
      if (abort_at > 0 && in_idx >= abort_at) break;
      in_valid[id] = (in_idx < n_in);
      in_data[id]  = in_pix(in_idx, w, h);
      case (ready_mode)
        0:       out_ready[id] = 1'b1;
        1:       out_ready[id] = 1'($urandom_range(0, 1));
        default: out_ready[id] = 1'b0;
      endcase
      if (first_valid < 0 && out_valid[id]) first_valid = cyc;
      if (!seen_full && in_idx == 2 * w) begin
        seen_full  = 1;
        ready_full = int'(in_ready[id]);
      end
      if (out_valid[id]) begin
        fk = out_idx % (w * s * h * s);
        check($sformatf("d%0d_data_%0d", id, out_idx), 32'(out_data[id]), 32'(out_pix(out_idx, w, h, s)));
        check($sformatf("d%0d_last_col_%0d", id, out_idx), 32'(out_last_col[id]),
              32'(fk % (w * s) == w * s - 1));
        check($sformatf("d%0d_last_frame_%0d", id, out_idx), 32'(out_last_frame[id]),
              32'(fk == w * s * h * s - 1));
      end
      if (in_valid[id] && in_ready[id]) begin
        if (in_idx == w - 1) row0_done = cyc;
        if (in_idx == 3 * w) tx_row3 = out_idx;
        in_idx++;
      end
      if (out_valid[id] && out_ready[id]) out_idx++;
    end
    in_valid[id] = 1'b0;
    if (abort_at == 0) begin
      check($sformatf("d%0d_in_count", id), 32'(in_idx), 32'(n_in));
      check($sformatf("d%0d_out_count", id), 32'(out_idx), 32'(n_out));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, r0, t3, rf;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; flush[i] = 1'b0; in_valid[i] = 1'b0;
      in_data[i] = '0; out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid_%0d", i), 32'(out_valid[i]), 0);
      check($sformatf("rst_in_ready_%0d", i), 32'(in_ready[i]), 0);
      check($sformatf("rst_busy_%0d", i), 32'(busy[i]), 0);
      check($sformatf("rst_out_data_%0d", i), 32'(out_data[i]), 0);
      rst_n[i] = 1'b1;
    end
    #1;
    check("rst_release_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    check("rst_first_edge_in_ready", 32'(in_ready[0]), 1);

    // 4x2, x2: two back-to-back frames at full rate
    run_stream(0, 4, 2, 2, 2, 0, 0, fv, r0, t3, rf);
    // Same configuration with random output backpressure
    run_stream(0, 4, 2, 2, 2, 1, 0, fv, r0, t3, rf);

    // 5 wide, x3: writer must wait for row 1's bank to be freed before row 3
    run_stream(1, 5, 4, 3, 1, 0, 0, fv, r0, t3, rf);
    check("s3_in_ready_both_full", 32'(rf), 0);
    check("s3_tx_before_row3", 32'(t3), 88);

    // Async reset in the middle of row 1, then a clean frame
    run_stream(0, 4, 2, 2, 1, 0, 6, fv, r0, t3, rf);
    #2 rst_n[0] = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid[0]), 0);
    check("midrst_out_data", 32'(out_data[0]), 0);
    check("midrst_last_col", 32'(out_last_col[0]), 0);
    check("midrst_last_frame", 32'(out_last_frame[0]), 0);
    check("midrst_in_ready", 32'(in_ready[0]), 0);
    check("midrst_busy", 32'(busy[0]), 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    run_stream(0, 4, 2, 2, 1, 0, 0, fv, r0, t3, rf);

    // Flush while stalled with valid output
    run_stream(0, 4, 2, 2, 1, 2, 8, fv, r0, t3, rf);
    repeat (3) @(negedge clk);
    check("flush_pre_out_valid", 32'(out_valid[0]), 1);
    check("flush_pre_in_ready", 32'(in_ready[0]), 0);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    check("flush_out_valid", 32'(out_valid[0]), 0);
    check("flush_busy", 32'(busy[0]), 0);
    check("flush_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    check("flush_in_ready_after", 32'(in_ready[0]), 1);
    run_stream(0, 4, 2, 2, 1, 0, 0, fv, r0, t3, rf);

    // SCALE=1 pass-through and first-output latency
    run_stream(2, 8, 3, 1, 1, 0, 0, fv, r0, t3, rf);
    check("s1_first_valid_latency", 32'(fv - r0), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
